// File: rtl/axil_master_cmd.sv
// Command-stream to AXI4-Lite master bridge: one outstanding read or write at a time,
// one response returned per accepted command.
module axil_master_cmd #(
    parameter int          ADDR_WIDTH = 4,
    parameter int          DATA_WIDTH = 32,
    parameter int          STRB_WIDTH = DATA_WIDTH / 8,
    parameter logic [2:0]  PROT       = 3'b000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_write_i,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
    input  logic [STRB_WIDTH-1:0] cmd_wstrb_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic                  rsp_write_o,
    output logic [DATA_WIDTH-1:0] rsp_rdata_o,
    output logic [1:0]            rsp_resp_o,
    output logic                  err_o,

    output logic [ADDR_WIDTH-1:0] axil_awaddr,
    output logic [2:0]            axil_awprot,
    output logic                  axil_awvalid,
    input  logic                  axil_awready,
    output logic [DATA_WIDTH-1:0] axil_wdata,
    output logic [STRB_WIDTH-1:0] axil_wstrb,
    output logic                  axil_wvalid,
    input  logic                  axil_wready,
    input  logic [1:0]            axil_bresp,
    input  logic                  axil_bvalid,
    output logic                  axil_bready,
    output logic [ADDR_WIDTH-1:0] axil_araddr,
    output logic [2:0]            axil_arprot,
    output logic                  axil_arvalid,
    input  logic                  axil_arready,
    input  logic [DATA_WIDTH-1:0] axil_rdata,
    input  logic [1:0]            axil_rresp,
    input  logic                  axil_rvalid,
    output logic                  axil_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  aw_done;
    logic                  w_done;

    logic aw_hs;
    logic w_hs;
    logic aw_now;
    logic w_now;

    assign aw_hs  = axil_awvalid && axil_awready;
    assign w_hs   = axil_wvalid && axil_wready;
    assign aw_now = aw_done || aw_hs;
    assign w_now  = w_done || w_hs;

    // Held off while reset is asserted so nothing can be accepted during reset.
    assign cmd_ready_o = (state == IDLE) && !rst_i;

    assign axil_awaddr = addr_q;
    assign axil_araddr = addr_q;
    assign axil_awprot = PROT;
    assign axil_arprot = PROT;
    assign axil_wdata  = wdata_q;
    assign axil_wstrb  = wstrb_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            axil_awvalid <= 1'b0;
            axil_wvalid  <= 1'b0;
            axil_bready  <= 1'b0;
            axil_arvalid <= 1'b0;
            axil_rready  <= 1'b0;
            rsp_valid_o  <= 1'b0;
            rsp_write_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_resp_o   <= 2'b00;
            err_o        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid_i) begin
                        addr_q  <= cmd_addr_i;
                        wdata_q <= cmd_wdata_i;
                        wstrb_q <= cmd_wstrb_i;
                        if (cmd_write_i) begin
                            axil_awvalid <= 1'b1;
                            axil_wvalid  <= 1'b1;
                            aw_done      <= 1'b0;
                            w_done       <= 1'b0;
                            state        <= WR_REQ;
                        end else begin
                            axil_arvalid <= 1'b1;
                            state        <= RD_REQ;
                        end
                    end
                end
                // AW and W complete independently; leave once both have handshaked.
                WR_REQ: begin
                    if (aw_hs) axil_awvalid <= 1'b0;
                    if (w_hs)  axil_wvalid  <= 1'b0;
                    aw_done <= aw_now;
                    w_done  <= w_now;
                    if (aw_now && w_now) begin
                        axil_bready <= 1'b1;
                        state       <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (axil_bvalid) begin
                        axil_bready <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_write_o <= 1'b1;
                        rsp_rdata_o <= '0;
                        rsp_resp_o  <= axil_bresp;
                        if (axil_bresp != 2'b00) err_o <= 1'b1;
                        state       <= RSP;
                    end
                end
                RD_REQ: begin
                    if (axil_arready) begin
                        axil_arvalid <= 1'b0;
                        axil_rready  <= 1'b1;
                        state        <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (axil_rvalid) begin
                        axil_rready <= 1'b0;
                        rsp_valid_o <= 1'b1;
                        rsp_write_o <= 1'b0;
                        rsp_rdata_o <= axil_rdata;
                        rsp_resp_o  <= axil_rresp;
                        if (axil_rresp != 2'b00) err_o <= 1'b1;
                        state       <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axil_master_cmd.sv
// Testbench for axil_master_cmd: a 4-register AXI-Lite slave with adjustable AW stall and
// BRESP, table-driven single commands, and directed multi-cycle sequences.
module tb_axil_master_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [3:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        err;

    logic [3:0]  awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [3:0]  araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int checks = 0;
    int failures = 0;
    int cycle_cnt = 0;

    axil_master_cmd dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_write_o(rsp_write),
        .rsp_rdata_o(rsp_rdata), .rsp_resp_o(rsp_resp), .err_o(err),
        .axil_awaddr(awaddr), .axil_awprot(awprot), .axil_awvalid(awvalid),
        .axil_awready(awready),
        .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
        .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
        .axil_araddr(araddr), .axil_arprot(arprot), .axil_arvalid(arvalid),
        .axil_arready(arready),
        .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Slave: awready stalls aw_lat cycles per request; writes land once both AW and W arrive.
    int          aw_lat = 0;
    int          aw_cnt;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [31:0] regs [4];
    logic        got_aw, got_w;
    logic [3:0]  s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;

    assign awready = (aw_cnt >= aw_lat);
    assign wready  = 1'b1;
    assign arready = 1'b1;

    always @(posedge clk or posedge rst) begin
        logic       aw_hs, w_hs;
        logic [3:0] a_use;
        logic [31:0] d_use;
        logic [3:0] s_use;
        if (rst) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
            aw_cnt   <= 0;
            got_aw   <= 1'b0;
            got_w    <= 1'b0;
            s_awaddr <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            bvalid   <= 1'b0;
            bresp    <= 2'b00;
            rvalid   <= 1'b0;
            rdata    <= '0;
            rresp    <= 2'b00;
        end else begin
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            a_use = aw_hs ? awaddr : s_awaddr;
            d_use = w_hs ? wdata : s_wdata;
            s_use = w_hs ? wstrb : s_wstrb;
            if (aw_hs) aw_cnt <= 0;
            else if (awvalid) aw_cnt <= aw_cnt + 1;
            if (aw_hs) s_awaddr <= awaddr;
            if (w_hs) begin
                s_wdata <= wdata;
                s_wstrb <= wstrb;
            end
            if ((got_aw || aw_hs) && (got_w || w_hs)) begin
                for (int b = 0; b < 4; b++)
                    if (s_use[b]) regs[a_use[3:2]][8*b +: 8] <= d_use[8*b +: 8];
                bvalid <= 1'b1;
                bresp  <= bresp_cfg;
                got_aw <= 1'b0;
                got_w  <= 1'b0;
            end else begin
                if (aw_hs) got_aw <= 1'b1;
                if (w_hs)  got_w  <= 1'b1;
                if (bvalid && bready) bvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                rvalid <= 1'b1;
                rdata  <= regs[araddr[3:2]];
                rresp  <= 2'b00;
            end else if (rvalid && rready) begin
                rvalid <= 1'b0;
            end
        end
    end

    // Negedge monitor: channel activity counters and a log of consumed responses.
    int          awvalid_cycles = 0;
    int          wvalid_cycles = 0;
    int          awaddr_bad = 0;
    int          b_hs_cnt = 0;
    logic [3:0]  awaddr_ref = '0;
    logic [3:0]  last_awaddr = '0;
    logic [31:0] last_wdata = '0;
    logic [3:0]  last_wstrb = '0;
    logic [3:0]  last_araddr = '0;
    logic        log_write [$];
    logic [31:0] log_rdata [$];
    int          log_cycle [$];

    always @(negedge clk) begin
        if (awvalid) begin
            awvalid_cycles++;
            if (awaddr != awaddr_ref) awaddr_bad++;
        end
        if (wvalid) wvalid_cycles++;
        if (awvalid && awready) last_awaddr = awaddr;
        if (wvalid && wready) begin
            last_wdata = wdata;
            last_wstrb = wstrb;
        end
        if (arvalid && arready) last_araddr = araddr;
        if (bvalid && bready) b_hs_cnt++;
        if (rsp_valid && rsp_ready) begin
            log_write.push_back(rsp_write);
            log_rdata.push_back(rsp_rdata);
            log_cycle.push_back(cycle_cnt);
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Presents one command, waits for its response (bounded) and returns the payload.
    task automatic apply_stimulus(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                                  input logic [3:0] strb, output logic ok, output int lat,
                                  output logic rw, output logic [31:0] rd, output logic [1:0] rr);
        int n;
        int t0;
        ok = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = data;
        cmd_wstrb = strb;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) ok = 1'b0;
        t0 = cycle_cnt;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) ok = 1'b0;
        lat = cycle_cnt - t0;
        rw  = rsp_write;
        rd  = rsp_rdata;
        rr  = rsp_resp;
    endtask

    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic        ok, rw;
        logic [31:0] rd;
        logic [1:0]  rr;
        logic [31:0] held_rdata;
        logic [1:0]  held_resp;
        logic        held_write;
        int          lat, n, nlog;
        logic        stable, blocked;

        vecs[0] = '{1'b1, 4'h4, 32'hDEADBEEF, 4'hF, 32'h0};
        vecs[1] = '{1'b0, 4'h4, 32'h0,        4'h0, 32'hDEADBEEF};
        vecs[2] = '{1'b1, 4'h8, 32'h11223344, 4'hF, 32'h0};
        vecs[3] = '{1'b1, 4'h8, 32'hAABBCCDD, 4'h5, 32'h0};
        vecs[4] = '{1'b0, 4'h8, 32'h0,        4'h0, 32'h11BB33DD};
        vecs[5] = '{1'b0, 4'hC, 32'h0,        4'h0, 32'h0};
        vecs[6] = '{1'b1, 4'hC, 32'hCAFEF00D, 4'hC, 32'h0};
        vecs[7] = '{1'b0, 4'hC, 32'h0,        4'h0, 32'hCAFE0000};

        #12;
        check_output("rst_awvalid", {31'd0, awvalid}, 32'd0);
        check_output("rst_wvalid", {31'd0, wvalid}, 32'd0);
        check_output("rst_arvalid", {31'd0, arvalid}, 32'd0);
        check_output("rst_bready_rready", {30'd0, bready, rready}, 32'd0);
        check_output("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_output("prot", {26'd0, awprot, arprot}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            apply_stimulus(vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb, ok, lat, rw, rd, rr);
            check_output($sformatf("vec%0d_handshake", i), {31'd0, ok}, 32'd1);
            check_output($sformatf("vec%0d_latency", i), lat, 32'd3);
            check_output($sformatf("vec%0d_rsp_write", i), {31'd0, rw}, {31'd0, vecs[i].wr});
            check_output($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check_output($sformatf("vec%0d_resp", i), {30'd0, rr}, 32'd0);
            if (vecs[i].wr) begin
                check_output($sformatf("vec%0d_awaddr", i), {28'd0, last_awaddr}, {28'd0, vecs[i].addr});
                check_output($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].data);
                check_output($sformatf("vec%0d_wstrb", i), {28'd0, last_wstrb}, {28'd0, vecs[i].strb});
            end else begin
                check_output($sformatf("vec%0d_araddr", i), {28'd0, last_araddr}, {28'd0, vecs[i].addr});
            end
        end

        // AW stalled 3 cycles while W is accepted at once.
        @(negedge clk);
        aw_lat = 3;
        awaddr_ref = 4'h4;
        awvalid_cycles = 0;
        wvalid_cycles = 0;
        awaddr_bad = 0;
        b_hs_cnt = 0;
        nlog = log_write.size();
        apply_stimulus(1'b1, 4'h4, 32'h12345678, 4'hF, ok, lat, rw, rd, rr);
        @(negedge clk);
        check_output("awstall_handshake", {31'd0, ok}, 32'd1);
        check_output("awstall_awvalid_cycles", awvalid_cycles, 32'd4);
        check_output("awstall_wvalid_cycles", wvalid_cycles, 32'd1);
        check_output("awstall_awaddr_stable", awaddr_bad, 32'd0);
        check_output("awstall_b_count", b_hs_cnt, 32'd1);
        check_output("awstall_rsp_count", log_write.size() - nlog, 32'd1);
        aw_lat = 0;

        // Error response, then a clean read must not clear the sticky flag.
        bresp_cfg = 2'b10;
        apply_stimulus(1'b1, 4'h0, 32'h0BAD0BAD, 4'hF, ok, lat, rw, rd, rr);
        check_output("slverr_resp", {30'd0, rr}, 32'd2);
        check_output("slverr_err", {31'd0, err}, 32'd1);
        bresp_cfg = 2'b00;
        apply_stimulus(1'b0, 4'h4, 32'h0, 4'h0, ok, lat, rw, rd, rr);
        check_output("okread_resp", {30'd0, rr}, 32'd0);
        check_output("okread_rdata", rd, 32'h12345678);
        check_output("okread_err_sticky", {31'd0, err}, 32'd1);

        // Response back-pressure: payload frozen and no new traffic until consumed.
        @(negedge clk);
        rsp_ready = 1'b0;
        apply_stimulus(1'b0, 4'h8, 32'h0, 4'h0, ok, lat, rw, rd, rr);
        held_write = rw;
        held_rdata = rd;
        held_resp  = rr;
        stable = 1'b1;
        blocked = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (!rsp_valid || rsp_write !== held_write || rsp_rdata !== held_rdata || rsp_resp !== held_resp)
                stable = 1'b0;
            if (cmd_ready || awvalid || arvalid) blocked = 1'b0;
            @(negedge clk);
        end
        check_output("hold_payload_stable", {31'd0, stable}, 32'd1);
        check_output("hold_blocked", {31'd0, blocked}, 32'd1);
        check_output("hold_rdata", held_rdata, 32'h11BB33DD);
        check_output("hold_valid_6th", {31'd0, rsp_valid}, 32'd1);
        rsp_ready = 1'b1;
        @(negedge clk);
        check_output("hold_release_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_output("hold_release_rsp_valid", {31'd0, rsp_valid}, 32'd0);

        // Reset while AW is pending: valids must fall without a clock edge.
        aw_lat = 10;
        nlog = log_write.size();
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 4'h4;
        cmd_wdata = 32'h55555555;
        cmd_wstrb = 4'hF;
        @(negedge clk);
        cmd_valid = 1'b0;
        check_output("midrst_awvalid_before", {31'd0, awvalid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("midrst_awvalid", {31'd0, awvalid}, 32'd0);
        check_output("midrst_wvalid", {31'd0, wvalid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        aw_lat = 0;
        @(negedge clk);
        check_output("midrst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check_output("midrst_err_cleared", {31'd0, err}, 32'd0);
        check_output("midrst_no_rsp", log_write.size() - nlog, 32'd0);

        // Four back-to-back commands with cmd_valid held high throughout.
        log_write.delete();
        log_rdata.delete();
        log_cycle.delete();
        cmd_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cmd_write = (i < 2);
            cmd_addr  = (i % 2 == 0) ? 4'h0 : 4'h8;
            cmd_wdata = (i % 2 == 0) ? 32'hA5A50001 : 32'h5A5A0002;
            cmd_wstrb = 4'hF;
            n = 0;
            while (!cmd_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            check_output($sformatf("b2b_accept%0d", i), {31'd0, cmd_ready}, 32'd1);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        n = 0;
        while (log_write.size() < 4 && n < 40) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_output("b2b_rsp_count", log_write.size(), 32'd4);
        if (log_write.size() == 4) begin
            check_output("b2b_order", {28'd0, log_write[0], log_write[1], log_write[2], log_write[3]},
                         32'b1100);
            check_output("b2b_rdata0", log_rdata[2], 32'hA5A50001);
            check_output("b2b_rdata8", log_rdata[3], 32'h5A5A0002);
            for (int i = 1; i < 4; i++)
                check_output($sformatf("b2b_gap%0d_ge4", i), {31'd0, (log_cycle[i] - log_cycle[i-1]) >= 4},
                             32'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
